// File: rtl/pipe_stall_regs.sv
// ---------------------------------------------------------------------------
// pipe_stall_regs
//
// Sequential half of the load-use hazard logic. Holds the fetch PC, the IF/ID
// and ID/EX pipeline registers, and applies the hazard detector's decisions:
//   - PCWr / IF_ID_Wr low  : freeze PC / IF/ID
//   - stall nonzero        : insert a bubble into ID/EX
//   - flush                : redirect PC to branch_target, squash IF/ID + ID/EX
//   - mem_stall            : freeze every register and counter
// Priority per edge: mem_stall > flush > normal (PCWr / IF_ID_Wr / stall).
// It also keeps saturating bubble / flush counters for performance debug.
//
// Ports
//   clk, rst                       clock (rising edge), async active-high reset
//   PCWr, IF_ID_Wr, stall          hazard detector controls
//   flush, branch_target           EX-stage redirect
//   mem_stall                      data memory not ready
//   imem_instr                     instruction fetched at pc
//   id_rs1..id_ctrl                decoded fields of the IF/ID instruction
//   pc                             current fetch PC
//   if_id_*                        IF/ID register contents
//   id_ex_*                        ID/EX register contents
//   ID_EX_MR, ID_EX_RW             qualified MemRead / RegWrite back to detector
//   bubble_cnt, flush_cnt          saturating performance counters
// ---------------------------------------------------------------------------
module pipe_stall_regs #(
    parameter int              XLEN     = 32,
    parameter int              CTRL_W   = 8,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PCWr,
    input  logic              IF_ID_Wr,
    input  logic [1:0]        stall,
    input  logic              flush,
    input  logic [XLEN-1:0]   branch_target,
    input  logic              mem_stall,
    input  logic [31:0]       imem_instr,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [XLEN-1:0]   id_rdata1,
    input  logic [XLEN-1:0]   id_rdata2,
    input  logic [CTRL_W-1:0] id_ctrl,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   if_id_pc,
    output logic [31:0]       if_id_instr,
    output logic              if_id_valid,
    output logic [XLEN-1:0]   id_ex_pc,
    output logic [4:0]        id_ex_rs1,
    output logic [4:0]        id_ex_rs2,
    output logic [4:0]        id_ex_rd,
    output logic [XLEN-1:0]   id_ex_imm,
    output logic [XLEN-1:0]   id_ex_rdata1,
    output logic [XLEN-1:0]   id_ex_rdata2,
    output logic [CTRL_W-1:0] id_ex_ctrl,
    output logic              id_ex_valid,
    output logic              ID_EX_MR,
    output logic              ID_EX_RW,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

    logic bubble_req;
    assign bubble_req = |stall;  // any nonzero stall code means bubble

    // PC and IF/ID
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else if (mem_stall) begin
            // hold everything; a pending flush is applied once memory is ready
        end else if (flush) begin
            pc          <= branch_target;
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else begin
            if (PCWr) begin
                pc <= pc + XLEN'(4);  // wraps silently at 2^XLEN
            end
            if (IF_ID_Wr) begin
                if_id_pc    <= pc;
                if_id_instr <= imem_instr;
                if_id_valid <= 1'b1;
            end
        end
    end

    // ID/EX: a bubble (flush or load-use) clears every field, not just valid,
    // so a squashed slot never looks like a stale instruction in a trace.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ex_pc     <= '0;
            id_ex_rs1    <= '0;
            id_ex_rs2    <= '0;
            id_ex_rd     <= '0;
            id_ex_imm    <= '0;
            id_ex_rdata1 <= '0;
            id_ex_rdata2 <= '0;
            id_ex_ctrl   <= '0;
            id_ex_valid  <= 1'b0;
        end else if (mem_stall) begin
            // hold
        end else if (flush || bubble_req) begin
            id_ex_pc     <= '0;
            id_ex_rs1    <= '0;
            id_ex_rs2    <= '0;
            id_ex_rd     <= '0;
            id_ex_imm    <= '0;
            id_ex_rdata1 <= '0;
            id_ex_rdata2 <= '0;
            id_ex_ctrl   <= '0;
            id_ex_valid  <= 1'b0;
        end else begin
            id_ex_pc     <= if_id_pc;
            id_ex_rs1    <= id_rs1;
            id_ex_rs2    <= id_rs2;
            id_ex_rd     <= id_rd;
            id_ex_imm    <= id_imm;
            id_ex_rdata1 <= id_rdata1;
            id_ex_rdata2 <= id_rdata2;
            // an invalid IF/ID slot must not carry live control into EX
            id_ex_ctrl   <= if_id_valid ? id_ctrl : '0;
            id_ex_valid  <= if_id_valid;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else if (!mem_stall) begin
            if (flush) begin
                if (flush_cnt != '1) begin
                    flush_cnt <= flush_cnt + 1'b1;
                end
            end else if (bubble_req) begin
                if (bubble_cnt != '1) begin
                    bubble_cnt <= bubble_cnt + 1'b1;
                end
            end
        end
    end

    assign ID_EX_MR = id_ex_ctrl[1] & id_ex_valid;
    assign ID_EX_RW = id_ex_ctrl[0] & id_ex_valid;

endmodule
